muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative, parametrised RISC-V M/RV64M multiply-divide unit. It sits beside the combinational ALU in EX.
//  It takes ALU opcodes 10-17 (MUL..REMU) and 38-42 (MULW..REMUW).
//  It replaces single-cycle '*', '/' and '%' with a valid/ready multi-cycle datapath.
//  Results are spec-correct, including MULH* high halves, divide-by-zero, signed overflow and W sign-extension.
// PARAMETERS
//  XLEN   64  datapath width; legal values 32, 64 (W ops illegal when XLEN=32)
//  OP_W   8   opcode width; matches the ALU instruction encoding
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      abort in-flight op (pipeline redirect)
//  in_valid   in   1      request present
//  in_ready   out  1      unit idle, can accept
//  op         in   OP_W   ALU opcode
//  rs1        in   XLEN   operand 1 value
//  rs2        in   XLEN   operand 2 value
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes result
//  result     out  XLEN   result value
//  illegal    out  1      qualifies out_valid: op was not an M opcode
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, result=0, illegal=0; in_ready=0 while reset is high, 1 from the next cycle.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid latches op/operands.
//    - Normal op: -> CALC.
//    - Special case (below): -> DONE directly, so out_valid rises 1 cycle after accept.
//  - CALC: one radix-2 step per cycle. N=XLEN steps, or N=32 for W ops. -> DONE after N steps.
//    - Accept at cycle 0 gives out_valid at cycle N+1.
//  - DONE: out_valid=1; result/illegal held stable until out_ready. out_valid&&out_ready -> IDLE.
//    - A back-to-back request is accepted no earlier than the cycle after the handshake.
//  Multiply: shift-add into a 2*XLEN accumulator, operands made unsigned with sign fix-up at the end.
//    - MUL returns prod[XLEN-1:0]. MULH/MULHSU/MULHU return prod[2*XLEN-1:XLEN].
//    - Signedness: MULH s*s, MULHSU s*u, MULHU u*u.
//  Divide: restoring division on absolute values; quotient and remainder signs fixed after the last step.
//    - Remainder takes the dividend's sign.
//  W ops: use rs1[31:0]/rs2[31:0] only; result = sign-extended 32-bit result, for DIVUW/REMUW too.
//  Special cases (resolved in 1 cycle, no CALC):
//    - divisor==0: DIV*/DIVU* -> all ones; REM*/REMU* -> dividend (W: sext of rs1[31:0]).
//    - signed overflow (min / -1): DIV -> min; REM -> 0. Applies to the W forms at 32-bit width.
//    - non-M opcode: result=0, illegal=1.
//  flush: highest priority in any state; next state IDLE, out_valid=0 next cycle, result discarded.
//    - flush together with in_valid in IDLE: request is dropped.
//  reset mid-operation: same as flush, plus outputs return to reset values.
//  in_valid while not IDLE: ignored (in_ready=0); upstream holds the request.
//  Step counter width is $clog2(XLEN)+1; it never wraps, because CALC exits at N.
// STRUCTURE
//  riscv_alu_pkg:
//    - localparam opcodes (OP_MUL=10 .. OP_REMU=17, OP_MULW=38 .. OP_REMUW=42).
//    - muldiv_state_t enum {IDLE, CALC, DONE}.
//    - helper functions is_mul / is_div / is_word / is_signed_a / is_signed_b.
//  Sub-module muldiv_divider_core: one restoring step per enable.
//    - Ports: clk, reset, load, step, dividend, divisor -> quotient, remainder.
//    - The multiplier stays inline in muldiv_unit.
// TESTING
//  1. MUL rs1=-3, rs2=7 -> result=-21, out_valid at cycle 65, illegal=0.
//  2. MULHU rs1=rs2=64'hFFFF_FFFF_FFFF_FFFF -> 64'hFFFF_FFFF_FFFF_FFFE.
//     MULH same operands -> 0. MULHSU rs1=-1, rs2=2 -> all ones.
//  3. DIV rs1=-7, rs2=2 -> -3; REM -> -1. DIVU 100/7 -> 14; REMU -> 2.
//  4. DIV rs1=5, rs2=0 -> all ones, out_valid at cycle 1; REM -> 5.
//     DIV rs1=64'h8000_0000_0000_0000, rs2=-1 -> 64'h8000_0000_0000_0000; REM -> 0.
//  5. DIVUW rs1=64'h1_8000_0000, rs2=1 -> 64'hFFFF_FFFF_8000_0000, out_valid at cycle 33.
//     MULW 32'h7FFF_FFFF*2 -> 64'hFFFF_FFFF_FFFF_FFFE.
//  6. flush at CALC cycle 10 -> out_valid never rises, in_ready=1 next cycle.
//     out_ready held low 5 cycles in DONE -> result stable.
//     op=0 (ADD) -> illegal=1, result=0.

Source files
------------

// File: rtl/riscv_alu_pkg.sv
// Package riscv_alu_pkg
// Purpose : shared opcode constants, the multiply/divide FSM state type and
//           small opcode-classification helpers for the M-extension unit.
// Contents:
//   OP_MUL..OP_REMU   full-width M opcodes (ALU encoding 10-17)
//   OP_MULW..OP_REMUW word M opcodes (ALU encoding 38-42)
//   muldiv_state_t    IDLE / CALC / DONE
//   is_mul / is_div / is_rem / is_word / is_signed_a / is_signed_b
package riscv_alu_pkg;

   localparam logic [7:0] OP_MUL    = 8'd10;
   localparam logic [7:0] OP_MULH   = 8'd11;
   localparam logic [7:0] OP_MULHSU = 8'd12;
   localparam logic [7:0] OP_MULHU  = 8'd13;
   localparam logic [7:0] OP_DIV    = 8'd14;
   localparam logic [7:0] OP_DIVU   = 8'd15;
   localparam logic [7:0] OP_REM    = 8'd16;
   localparam logic [7:0] OP_REMU   = 8'd17;
   localparam logic [7:0] OP_MULW   = 8'd38;
   localparam logic [7:0] OP_DIVW   = 8'd39;
   localparam logic [7:0] OP_DIVUW  = 8'd40;
   localparam logic [7:0] OP_REMW   = 8'd41;
   localparam logic [7:0] OP_REMUW  = 8'd42;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } muldiv_state_t;

   function automatic logic is_mul(input logic [7:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
   endfunction

   function automatic logic is_div(input logic [7:0] op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                        OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
   endfunction

   function automatic logic is_rem(input logic [7:0] op);
      return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
   endfunction

   function automatic logic is_word(input logic [7:0] op);
      return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
   endfunction

   // MUL/MULW only need the low product bits, which do not depend on
   // signedness, so treating them as signed is harmless.
   function automatic logic is_signed_a(input logic [7:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                        OP_MULW, OP_DIVW, OP_REMW};
   endfunction

   function automatic logic is_signed_b(input logic [7:0] op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM,
                        OP_MULW, OP_DIVW, OP_REMW};
   endfunction

endpackage

// File: rtl/muldiv_divider_core.sv
// Module muldiv_divider_core
// Purpose : unsigned restoring divider, one quotient bit per step pulse.
//           The dividend is shifted out MSB-first from the quotient register
//           while quotient bits are shifted in at the bottom.
// Ports   :
//   clk, reset            clock, synchronous active-high reset
//   load                  capture dividend/divisor, clear partial remainder
//   step                  perform one restoring step
//   dividend, divisor     unsigned operands (XLEN)
//   quotient, remainder   current quotient / partial remainder (XLEN)
module muldiv_divider_core #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] quot_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] dsor_q;
   logic [XLEN:0]   trial;
   logic            fits;
   logic [XLEN-1:0] rem_next;

   // The trial value is one bit wider than the divisor so that a full-width
   // divisor can still be compared without overflow.
   always_comb begin
      trial    = {rem_q, quot_q[XLEN-1]};
      fits     = (trial >= {1'b0, dsor_q});
      rem_next = fits ? XLEN'(trial - {1'b0, dsor_q}) : trial[XLEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quot_q <= '0;
         rem_q  <= '0;
         dsor_q <= '0;
      end else if (load) begin
         quot_q <= dividend;
         rem_q  <= '0;
         dsor_q <= divisor;
      end else if (step) begin
         rem_q  <= rem_next;
         quot_q <= {quot_q[XLEN-2:0], fits};
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Module muldiv_unit
// Purpose : iterative RISC-V M / RV64M multiply-divide unit with a
//           valid/ready interface, sitting beside the EX-stage ALU.
//           Multiplies by shift-add, divides by restoring division, both on
//           magnitudes with a sign fix-up applied to the final registers.
//           Divide-by-zero, signed overflow and non-M opcodes finish in one
//           cycle without entering CALC.
// Ports   :
//   clk, reset            clock, synchronous active-high reset
//   flush                 abort any in-flight operation
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   op, rs1, rs2          ALU opcode and operands
//   out_valid / out_ready result handshake
//   result                XLEN result, zero unless out_valid
//   illegal               op was not an M opcode (qualifies out_valid)
module muldiv_unit
   import riscv_alu_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int OP_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam int PW    = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t state;
   muldiv_state_t state_next;

   // Request decode
   logic [7:0]      op_code;
   logic            word;
   logic            legal;
   logic            sign_a;
   logic            sign_b;
   logic            a_neg;
   logic            b_neg;
   logic [31:0]     a_m32;
   logic [31:0]     b_m32;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] a_val;
   logic            b_zero;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] special_res;
   logic            accept;

   // Latched operation
   logic [7:0]      op_q;
   logic            word_q;
   logic            mul_q;
   logic            is_rem_q;
   logic            neg_q;
   logic            rem_neg_q;
   logic            special_q;
   logic            illegal_q;
   logic [XLEN-1:0] special_res_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] steps_q;

   // Multiplier datapath
   logic [PW-1:0]   mcand_q;
   logic [XLEN-1:0] mplier_q;
   logic [PW-1:0]   prod_q;

   // Divider interface
   logic            div_load;
   logic            div_step;
   logic [XLEN-1:0] div_dividend;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

   // Result assembly
   logic [PW-1:0]   prod_fix;
   logic [XLEN-1:0] quot_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] mul_res;
   logic [XLEN-1:0] div_res;
   logic [XLEN-1:0] calc_res;

   // Classify the incoming request and turn the operands into magnitudes.
   // W ops look only at the low 32 bits; their magnitudes are zero-extended
   // so the shared datapath sees a plain unsigned value. Special cases are
   // resolved here so IDLE can jump straight to DONE.
   always_comb begin
      op_code  = 8'(op);
      word     = is_word(op_code);
      legal    = (is_mul(op_code) || is_div(op_code)) && !(word && (XLEN == 32));
      sign_a   = is_signed_a(op_code);
      sign_b   = is_signed_b(op_code);
      a_neg    = 1'b0;
      b_neg    = 1'b0;
      a_m32    = '0;
      b_m32    = '0;
      a_mag    = '0;
      b_mag    = '0;
      a_val    = '0;
      b_zero   = 1'b0;
      overflow = 1'b0;
      if (word) begin
         a_neg    = sign_a && rs1[31];
         b_neg    = sign_b && rs2[31];
         a_m32    = a_neg ? (~rs1[31:0] + 32'd1) : rs1[31:0];
         b_m32    = b_neg ? (~rs2[31:0] + 32'd1) : rs2[31:0];
         a_mag    = XLEN'(a_m32);
         b_mag    = XLEN'(b_m32);
         a_val    = XLEN'($signed(rs1[31:0]));
         b_zero   = (rs2[31:0] == 32'd0);
         overflow = sign_a && (rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF);
      end else begin
         a_neg    = sign_a && rs1[XLEN-1];
         b_neg    = sign_b && rs2[XLEN-1];
         a_mag    = a_neg ? (~rs1 + XLEN'(1)) : rs1;
         b_mag    = b_neg ? (~rs2 + XLEN'(1)) : rs2;
         a_val    = rs1;
         b_zero   = (rs2 == '0);
         overflow = sign_a && (rs1 == MIN_VAL) && (rs2 == '1);
      end

      // For signed overflow the quotient equals the dividend itself.
      special     = 1'b0;
      special_res = '0;
      if (!legal) begin
         special = 1'b1;
      end else if (is_div(op_code) && b_zero) begin
         special     = 1'b1;
         special_res = is_rem(op_code) ? a_val : '1;
      end else if (is_div(op_code) && overflow) begin
         special     = 1'b1;
         special_res = is_rem(op_code) ? '0 : a_val;
      end
   end

   assign accept = in_valid && in_ready && !flush;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. flush overrides everything.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !reset;
            if (in_valid) begin
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == steps_q - CNT_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   // Operation latch, step counter and the inline shift-add multiplier.
   // The multiplicand lives in a 2*XLEN register that shifts left each step,
   // so every step is a single conditional add.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q          <= '0;
         word_q        <= 1'b0;
         mul_q         <= 1'b0;
         is_rem_q      <= 1'b0;
         neg_q         <= 1'b0;
         rem_neg_q     <= 1'b0;
         special_q     <= 1'b0;
         illegal_q     <= 1'b0;
         special_res_q <= '0;
         cnt           <= '0;
         steps_q       <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         prod_q        <= '0;
      end else if (accept) begin
         op_q          <= op_code;
         word_q        <= word;
         mul_q         <= is_mul(op_code);
         is_rem_q      <= is_rem(op_code);
         neg_q         <= a_neg ^ b_neg;
         rem_neg_q     <= a_neg;
         special_q     <= special;
         illegal_q     <= !legal;
         special_res_q <= special_res;
         cnt           <= '0;
         steps_q       <= word ? CNT_W'(32) : CNT_W'(XLEN);
         mcand_q       <= {{XLEN{1'b0}}, a_mag};
         mplier_q      <= b_mag;
         prod_q        <= '0;
      end else if ((state == CALC) && !flush) begin
         cnt <= cnt + CNT_W'(1);
         if (mul_q) begin
            prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
         end
      end
   end

   // W dividends are pre-shifted to the top so that 32 steps consume exactly
   // their 32 significant bits.
   assign div_load     = accept && legal && !special && is_div(op_code);
   assign div_step     = (state == CALC) && !mul_q && !flush;
   assign div_dividend = word ? (a_mag << (XLEN - 32)) : a_mag;

   muldiv_divider_core #(
      .XLEN (XLEN)
   ) u_divider (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .step      (div_step),
      .dividend  (div_dividend),
      .divisor   (b_mag),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Sign fix-up and result selection from the final datapath registers.
   // These registers are frozen in DONE, so the result stays stable until
   // the consumer takes it.
   always_comb begin
      prod_fix = neg_q ? (~prod_q + PW'(1)) : prod_q;
      quot_fix = neg_q ? (~quotient + XLEN'(1)) : quotient;
      rem_fix  = rem_neg_q ? (~remainder + XLEN'(1)) : remainder;

      if (op_q == OP_MUL) begin
         mul_res = prod_fix[XLEN-1:0];
      end else if (op_q == OP_MULW) begin
         mul_res = XLEN'($signed(prod_fix[31:0]));
      end else begin
         mul_res = prod_fix[PW-1:XLEN];
      end

      div_res = is_rem_q ? rem_fix : quot_fix;
      if (word_q) begin
         div_res = XLEN'($signed(div_res[31:0]));
      end

      if (special_q) begin
         calc_res = special_res_q;
      end else if (mul_q) begin
         calc_res = mul_res;
      end else begin
         calc_res = div_res;
      end
   end

   assign result  = (state == DONE) ? calc_res : '0;
   assign illegal = (state == DONE) && illegal_q;

endmodule
